// File: rtl/m_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch (I) and load/store (D)
// ports. D wins by default; a bounded D streak guarantees I forward progress.
module m_mem_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_i_req,
    input  logic [AW-1:0] w_i_addr,
    output logic          w_i_done,
    output logic [DW-1:0] w_i_rdata,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    output logic          w_d_done,
    output logic [DW-1:0] w_d_rdata,
    output logic          w_mem_req,
    output logic          w_mem_we,
    output logic [AW-1:0] w_mem_addr,
    output logic [DW-1:0] w_mem_wdata,
    input  logic          w_mem_ack,
    input  logic [DW-1:0] w_mem_rdata,
    output logic          w_stall
);

    typedef enum logic [2:0] {StIdle, StBusyI, StBusyD, StRespI, StRespD} state_e;

    localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

    state_e        state_q, state_d;
    logic [3:0]    streak_q, streak_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          grant_i;

    // I wins when D is idle, or when D has used up its streak while I was waiting.
    assign grant_i = w_i_req & (~w_d_req | (streak_q == MaxStreak));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = w_i_addr;
                    streak_d   = 4'd0;
                    state_d    = StBusyI;
                end else if (w_d_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = w_d_we;
                    mem_addr_d  = w_d_addr;
                    mem_wdata_d = w_d_wdata;
                    streak_d    = w_i_req ? streak_q + 4'd1 : 4'd0;
                    state_d     = StBusyD;
                end
            end
            StBusyI: begin
                if (w_mem_ack) begin
                    mem_req_d = 1'b0;
                    i_rdata_d = w_mem_rdata;
                    state_d   = StRespI;
                end
            end
            StBusyD: begin
                if (w_mem_ack) begin
                    mem_req_d = 1'b0;
                    d_rdata_d = w_mem_rdata;
                    state_d   = StRespD;
                end
            end
            StRespI, StRespD: state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q     <= StIdle;
            streak_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign w_i_done    = (state_q == StRespI);
    assign w_d_done    = (state_q == StRespD);
    assign w_i_rdata   = i_rdata_q;
    assign w_d_rdata   = d_rdata_q;
    assign w_mem_req   = mem_req_q;
    assign w_mem_we    = mem_we_q;
    assign w_mem_addr  = mem_addr_q;
    assign w_mem_wdata = mem_wdata_q;
    assign w_stall     = (w_i_req & ~w_i_done) | (w_d_req & ~w_d_done);

endmodule
